// File: rtl/alu_cmd_ctrl.sv
// Command-side controller: parses 0xCC/0xDD byte frames, fires the ALU once and returns the
// 16-bit result low byte first. Optional DROP_CNT_EN adds a saturating dropped-byte counter.
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [3:0]              alu_fun,
  output logic                    alu_en,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    err,
`ifdef DROP_CNT_EN
  output logic [7:0]              drop_cnt,
`endif
  output logic [2:0]              state_dbg
);

  localparam logic [7:0] OP_LOAD_EXEC = 8'hCC;
  localparam logic [7:0] OP_EXEC      = 8'hDD;
  localparam int         CW           = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_A, S_GET_B, S_GET_FUN, S_ISSUE, S_WAIT_RES, S_SEND_LO, S_SEND_HI
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [7:0]    res_hi;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // TX handshake: a byte transfers on any clock edge where tx_valid and tx_ready are both high;
  // tx_valid/tx_data are registers and only change after such an edge, never from tx_ready directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_fun  <= '0;
      alu_en   <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= '0;
      res_hi   <= '0;
    end else begin
      alu_en <= 1'b0;
      err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            if (rx_data == OP_LOAD_EXEC)  state <= S_GET_A;
            else if (rx_data == OP_EXEC)  state <= S_GET_FUN;
            else                          err   <= 1'b1;
          end
        end
        S_GET_A: begin
          if (rx_valid) begin
            alu_a <= rx_data[DATA_WIDTH-1:0];
            state <= S_GET_B;
          end
        end
        S_GET_B: begin
          if (rx_valid) begin
            alu_b <= rx_data[DATA_WIDTH-1:0];
            state <= S_GET_FUN;
          end
        end
        S_GET_FUN: begin
          if (rx_valid) begin
            alu_fun <= rx_data[3:0];
            alu_en  <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT_RES;
        end
        S_WAIT_RES: begin
          // A valid on the final wait cycle still wins over the timeout.
          if (alu_out_valid) begin
            tx_data  <= alu_out[7:0];
            res_hi   <= alu_out[15:8];
            tx_valid <= 1'b1;
            state    <= S_SEND_LO;
          end else if (wait_cnt == WAIT_LAST) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_SEND_LO: begin
          if (tx_ready) begin
            tx_data <= res_hi;
            state   <= S_SEND_HI;
          end
        end
        S_SEND_HI: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (rx_valid) begin
      if (state == S_IDLE && rx_data == OP_LOAD_EXEC)
        drop_cnt <= '0;
      else if ((state inside {S_ISSUE, S_WAIT_RES, S_SEND_LO, S_SEND_HI}) && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: a two-stage ALU stand-in, a frame-level reference model feeding
// expected-byte and expected-issue queues, directed cases then randomized frames.
module tb_alu_cmd_ctrl;
  localparam int DW = 8;
  localparam int WC = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [DW-1:0] alu_a, alu_b;
  logic [3:0]    alu_fun;
  logic          alu_en;
  logic [15:0]   alu_out;
  logic          alu_out_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          busy, err;
  logic [2:0]    state_dbg;
`ifdef DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  always #5 clk = ~clk;

  alu_cmd_ctrl #(.DATA_WIDTH(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_en(alu_en),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .err(err),
`ifdef DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_rx_cyc = 0;
  int en_seen = 0, err_seen = 0, en_cyc = 0, err_cyc = 0;
  int exp_en = 0, exp_err = 0, exp_drop = 0;
  int tx_mode = 0;  // 0: ready high, 1: random, 2: driven by main
  logic [7:0]  m_a = 8'h00, m_b = 8'h00;
  logic [7:0]  exp_q[$];
  logic [19:0] iss_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
    case (f)
      4'h0: return 16'(a) + 16'(b);
      4'h1: return 16'(a) - 16'(b);
      4'h2: return 16'(a) * 16'(b);
      4'h3: return {8'h00, a & b};
      4'h4: return {8'h00, a | b};
      4'h5: return {8'h00, a ^ b};
      default: return {a, b};
    endcase
  endfunction

  // ALU stand-in: result valid two edges after it samples alu_en; FUN 0xF never answers.
  logic        p1_v;
  logic [15:0] p1_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= 1'b0; p1_r <= '0; alu_out_valid <= 1'b0; alu_out <= '0;
    end else begin
      p1_v          <= alu_en && (alu_fun != 4'hF);
      p1_r          <= alu_ref(alu_a, alu_b, alu_fun);
      alu_out_valid <= p1_v;
      alu_out       <= p1_v ? p1_r : 16'($urandom);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    if (tx_mode == 0)      tx_ready = 1'b1;
    else if (tx_mode == 1) tx_ready = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard: sampled mid-cycle, so a handshake seen here completes on the next edge.
  always @(negedge clk) begin
    if (alu_en) begin
      en_seen++;
      en_cyc = cyc;
      check_eq("issue_expected", 32'(iss_q.size() != 0), 1);
      if (iss_q.size() != 0) check_eq("alu_operands", {alu_a, alu_b, alu_fun}, iss_q.pop_front());
    end
    if (tx_valid && tx_ready) begin
      check_eq("tx_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_eq("tx_byte", tx_data, exp_q.pop_front());
    end
    if (err) begin
      err_seen++;
      err_cyc = cyc;
    end
  end

  // Frame-level model: one execution with the stored operands.
  task automatic model_exec(input logic [3:0] f);
    logic [15:0] r;
    exp_en++;
    iss_q.push_back({m_a, m_b, f});
    if (f == 4'hF) exp_err++;
    else begin
      r = alu_ref(m_a, m_b, f);
      exp_q.push_back(r[7:0]);
      exp_q.push_back(r[15:8]);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    last_rx_cyc = cyc;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic junk_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      rx_byte(8'($urandom));
      if (exp_drop < 255) exp_drop++;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin @(posedge clk); #1; k++; end
    check_eq("wait_idle", busy, 0);
  endtask

  task automatic wait_tx_valid();
    int k = 0;
    while (tx_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    check_eq("tx_valid_seen", tx_valid, 1);
  endtask

  task automatic send_cc(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f8,
                         input int junk, input int max_gap);
    m_a = a; m_b = b; exp_drop = 0;
    model_exec(f8[3:0]);
    rx_byte(8'hCC); gap($urandom_range(0, max_gap));
    rx_byte(a);     gap($urandom_range(0, max_gap));
    rx_byte(b);     gap($urandom_range(0, max_gap));
    rx_byte(f8);
    junk_bytes(junk);
  endtask

  task automatic send_dd(input logic [7:0] f8, input int junk, input int max_gap);
    model_exec(f8[3:0]);
    rx_byte(8'hDD); gap($urandom_range(0, max_gap));
    rx_byte(f8);
    junk_bytes(junk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_alu_a"}, alu_a, 0);
    check_eq({tag, "_alu_b"}, alu_b, 0);
    check_eq({tag, "_alu_fun"}, alu_fun, 0);
    check_eq({tag, "_alu_en"}, alu_en, 0);
    check_eq({tag, "_tx"}, {tx_valid, tx_data}, 0);
    check_eq({tag, "_busy_err"}, {busy, err}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx_seen;
    logic [7:0] b;
    logic [3:0] f;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1;
    gap(2);

    // Add: 5 + 3, checks issue latency to first response byte
    m_a = 8'h05; m_b = 8'h03; exp_drop = 0;
    model_exec(4'h0);
    rx_byte(8'hCC); rx_byte(8'h05); rx_byte(8'h03); rx_byte(8'h00);
    wait_tx_valid();
    check_eq("latency_fun_to_tx", cyc - last_rx_cyc, 3);
    wait_idle();
    check_eq("add_err", err_seen, exp_err);

    // Multiply 0xFF*0xFF then reuse of stored operands
    send_cc(8'hFF, 8'hFF, 8'h02, 0, 2); wait_idle();
    send_dd(8'h01, 0, 2);               wait_idle();
    check_eq("mul_sub_queue", exp_q.size(), 0);

    // Receiver stalls: low byte must be held steady
    tx_mode = 2; tx_ready = 1'b0;
    m_a = 8'hFF; m_b = 8'hFF;
    model_exec(4'h2);
    rx_byte(8'hCC); rx_byte(8'hFF); rx_byte(8'hFF); rx_byte(8'h02);
    wait_tx_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hold_lo", {tx_valid, tx_data}, {1'b1, 8'h01});
    end
    check_eq("hold_no_hi", exp_q.size(), 2);
    @(posedge clk); #1;
    tx_ready = 1'b1; tx_mode = 0;
    wait_idle();

    // FUN 0xF: ALU never answers, controller times out
    m_a = 8'h01; m_b = 8'h02; exp_drop = 0;
    model_exec(4'hF);
    rx_byte(8'hCC); rx_byte(8'h01); rx_byte(8'h02); rx_byte(8'h0F);
    tx_seen = 0;
    repeat (20) begin @(negedge clk); if (tx_valid) tx_seen++; end
    check_eq("timeout_no_tx", tx_seen, 0);
    check_eq("timeout_delay", err_cyc - en_cyc, WC + 1);
    check_eq("timeout_busy", busy, 0);
    check_eq("timeout_err", err_seen, exp_err);

    // Unknown opcode
    @(posedge clk); #1;
    exp_err++;
    rx_byte(8'h12);
    check_eq("unk_err", err, 1);
    check_eq("unk_busy", busy, 0);
    gap(1);
    check_eq("unk_err_pulse", err, 0);
    send_dd(8'h04, 0, 1); wait_idle();
    check_eq("unk_err_total", err_seen, exp_err);

    // Reset mid-frame clears stored operands
    rx_byte(8'hCC); rx_byte(8'h07);
    rst_n = 1'b0;
    m_a = 8'h00; m_b = 8'h00; exp_drop = 0;
    @(negedge clk);
    check_reset_outputs("rst1");
    @(posedge clk); #1;
    rst_n = 1'b1;
    gap(1);
    send_dd(8'h00, 0, 1); wait_idle();
    check_eq("post_reset_queue", exp_q.size(), 0);

    // Randomized frames with backpressure and bytes arriving while busy
    tx_mode = 1;
    for (int n = 0; n < 40; n++) begin
      int kind = $urandom_range(0, 9);
      f = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 5));
      if (kind == 0) begin
        do b = 8'($urandom); while (b == 8'hCC || b == 8'hDD);
        exp_err++;
        rx_byte(b);
      end else if (kind <= 5) begin
        send_cc(8'($urandom), 8'($urandom), {4'($urandom), f}, $urandom_range(0, 4), 2);
      end else begin
        send_dd({4'($urandom), f}, $urandom_range(0, 4), 2);
      end
      wait_idle();
      gap(1);
      check_eq("rand_drained", exp_q.size(), 0);
`ifdef DROP_CNT_EN
      check_eq("drop_cnt", drop_cnt, exp_drop);
`endif
      gap($urandom_range(0, 2));
    end

    tx_mode = 0;
    gap(5);
    check_eq("final_tx_queue", exp_q.size(), 0);
    check_eq("final_issue_queue", iss_q.size(), 0);
    check_eq("final_en_cycles", en_seen, exp_en);
    check_eq("final_err_cycles", err_seen, exp_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
